// File: rtl/multi_btn_debouncer.sv
// multi_btn_debouncer: N-channel synchronised, tick-sampled push-button debouncer with
// a clean level plus one-cycle press, release and long-press pulses per channel.
module multi_btn_debouncer #(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10,
  parameter int LONG_TICKS   = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_p,
  output logic [N_CH-1:0] long_press
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STABLE_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STABLE_N = SW'(STABLE_TICKS);
  localparam logic [HW-1:0] LONG_N   = HW'(LONG_TICKS);
  typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [N_CH-1:0] sync1_q, sync2_q;
  logic            tick;
  always_comb begin
    tick   = tcnt_q == TICK_MAX;
    tcnt_d = tick ? '0 : tcnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      tcnt_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      tcnt_q  <= tcnt_d;
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_t        st_q, st_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          fired_q, fired_d, prs_q, prs_d, rls_q, rls_d, lng_q, lng_d;
    logic          s;
    always_comb begin
      s       = sync2_q[i];
      st_d    = st_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      fired_d = fired_q;
      prs_d   = 1'b0;
      rls_d   = 1'b0;
      lng_d   = 1'b0;
      if (tick) begin
        case (st_q)
          LOW: begin
            st_d  = s ? WAIT_HIGH : LOW;
            cnt_d = s ? SW'(1) : '0;
          end
          WAIT_HIGH: begin
            if (!s) begin
              st_d  = LOW;
              cnt_d = '0;
            end else if (cnt_q + 1'b1 == STABLE_N) begin
              st_d    = HIGH;
              cnt_d   = '0;
              prs_d   = 1'b1;
              hold_d  = '0;
              fired_d = 1'b0;
            end else cnt_d = cnt_q + 1'b1;
          end
          HIGH: begin
            if (s) begin
              hold_d  = (hold_q == LONG_N) ? hold_q : hold_q + 1'b1;
              lng_d   = (hold_d == LONG_N) && !fired_q;
              fired_d = fired_q || lng_d;
            end else begin
              st_d  = WAIT_LOW;
              cnt_d = SW'(1);
            end
          end
          WAIT_LOW: begin
            // hold count and fired flag survive a bounce back to HIGH
            if (s) begin
              st_d  = HIGH;
              cnt_d = '0;
            end else if (cnt_q + 1'b1 == STABLE_N) begin
              st_d  = LOW;
              cnt_d = '0;
              rls_d = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
          end
        endcase
      end
    end
    always_ff @(posedge clk) begin
      if (!rst) begin
        st_q    <= LOW;
        cnt_q   <= '0;
        hold_q  <= '0;
        fired_q <= 1'b0;
        prs_q   <= 1'b0;
        rls_q   <= 1'b0;
        lng_q   <= 1'b0;
      end else begin
        st_q    <= st_d;
        cnt_q   <= cnt_d;
        hold_q  <= hold_d;
        fired_q <= fired_d;
        prs_q   <= prs_d;
        rls_q   <= rls_d;
        lng_q   <= lng_d;
      end
    end
    assign level[i]      = (st_q == HIGH) || (st_q == WAIT_LOW);
    assign press[i]      = prs_q;
    assign release_p[i]  = rls_q;
    assign long_press[i] = lng_q;
  end
endmodule

// File: doc/multi_btn_debouncer.md
Name: multi_btn_debouncer

Overview:
Parametrised N-channel FSM push-button debouncer, successor to the single-button debouncer in the display top level. Each channel has its own synchroniser, its own debounce FSM and a long-press detector. All channels share one clock-enable tick generator. Outputs are a clean level plus one-cycle press, release and long-press pulses, consumed by the display/control logic.

Parameters:
N_CH, 4, number of independent button channels (>=1)
TICK_DIV, 100000, clk cycles per sample tick (>=2); tick is 1 ms at 100 MHz
STABLE_TICKS, 10, consecutive equal samples needed to accept a transition (>=2)
LONG_TICKS, 1000, ticks held HIGH before long_press fires (>STABLE_TICKS)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low: clears state on a rising clk edge while rst=0
btn  in  N_CH  raw asynchronous button inputs, active-high
level  out  N_CH  debounced button level
press  out  N_CH  one-cycle pulse on accepted 0->1 transition
release  out  N_CH  one-cycle pulse on accepted 1->0 transition
long_press  out  N_CH  one-cycle pulse, at most once per press, after LONG_TICKS held

Behaviour:
- Reset (rst=0 at clk edge):
  - tick counter=0; both synchroniser stages=0.
  - Every channel: state=LOW, sample cnt=0, hold cnt=0, long-fired flag=0.
  - All outputs=0 from the edge on which reset is sampled, mid-operation included; no pulse is emitted on reset entry or exit.
- Tick:
  - Free-running counter 0..TICK_DIV-1, width $clog2(TICK_DIV).
  - tick=1 for exactly one cycle when counter==TICK_DIV-1, then counter wraps to 0.
  - First tick occurs TICK_DIV cycles after reset release.
- Synchroniser: 2 flip-flops per channel; s[i] is the synchronised btn[i].
- Per-channel FSM:
  - Evaluated only on tick cycles; holds otherwise.
  - Counter widths: $clog2(STABLE_TICKS+1) for sample cnt, $clog2(LONG_TICKS+1) for hold cnt.
- LOW (level=0):
  - s=1 -> WAIT_HIGH, cnt=1.
  - s=0 -> stay.
- WAIT_HIGH (level=0):
  - s=0 -> LOW, cnt=0.
  - s=1 and cnt+1==STABLE_TICKS -> HIGH, level<=1, press pulse, hold cnt=0, long-fired=0.
  - Otherwise cnt<=cnt+1.
- HIGH (level=1):
  - s=1: hold cnt increments, saturating at LONG_TICKS. On the tick where hold cnt reaches LONG_TICKS and long-fired=0: long_press pulse, long-fired<=1.
  - s=0 -> WAIT_LOW, cnt=1.
- WAIT_LOW (level=1):
  - s=1 -> HIGH, cnt=0. hold cnt and long-fired are preserved, so a bounce cannot re-fire long_press.
  - s=0 and cnt+1==STABLE_TICKS -> LOW, level<=0, release pulse.
  - Otherwise cnt<=cnt+1.
- Outputs are registered:
  - level, press, release and long_press change on the clk edge that ends the deciding tick cycle.
  - Pulses are exactly 1 clk wide. Pulses are never asserted on non-tick-derived cycles.
- Latency: a clean edge on btn reaches level/press after 2 (sync) + 0..TICK_DIV-1 (tick phase) + (STABLE_TICKS-1)*TICK_DIV + 1 cycles.
- Glitches: any glitch shorter than STABLE_TICKS-1 ticks produces no level change and no pulse.
- Channels are fully independent:
  - Simultaneous events on several channels produce simultaneous pulses on those bits.
  - press and release can never both be 1 on the same bit.

Test Plan:
Bench params N_CH=2, TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=6; clk period 20 ns.
1. Reset: rst=0 for 2 cycles with btn=2'b11 -> all outputs 0; after release, first tick at cycle 4; no press pulse until 3 consecutive high samples.
2. Clean press, btn[0]=1 held 20 cycles:
   - level[0] rises 11..14 cycles after the edge; press[0]=1 for exactly 1 cycle.
   - level[1], press[1] stay 0.
3. Bounce, btn[0] toggling 1/0 every 5 cycles for 40 cycles then 0 -> level[0]=0 throughout; press=release=0.
4. Long press, btn[1]=1 held 60 cycles:
   - press[1] once, then long_press[1] once, 6 ticks (24 cycles) after press.
   - A single 3-cycle 0-glitch afterwards does not re-fire long_press.
   - Final release gives exactly one release[1] pulse.
5. Simultaneous: btn=2'b11 on the same edge -> press=2'b11 in the same cycle; later btn=2'b00 -> release=2'b11 in the same cycle.
6. Reset mid-WAIT_HIGH: rst=0 for 1 cycle while btn[0] has 2 good samples -> no press; with btn still 1, press[0] fires after a fresh 3 samples.
